frame_update_scheduler: RTL and testbench

Sequences per-frame game-state updates for StarSoC. On each vsync rising edge it grants N_REQ update requesters (sprite/object engines) exclusive, one-at-a-time access to shared game-state resources during vertical blanking. Starting order rotates per frame; each grant is bounded by a watchdog. Sits beside video_gen in the pixel_clk domain, fed by hdmi_timing's vsync and video_on.

---
 rtl/frame_update_scheduler_pkg.sv | 9 +
 rtl/frame_update_scheduler_edge_detect.sv | 26 ++
 rtl/frame_update_scheduler.sv | 168 ++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_update_scheduler_pkg.sv
// rtl/frame_update_scheduler_pkg.sv - shared state encoding and default sizing for the frame update scheduler
package frame_update_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, FINISH} sched_state_t;

  localparam int SCHED_N_REQ   = 4;
  localparam int SCHED_TIMEOUT = 1024;

endpackage

// File: rtl/frame_update_scheduler_edge_detect.sv
// rtl/frame_update_scheduler_edge_detect.sv - registered rising-edge detector for timing strobes
module frame_update_scheduler_edge_detect (
  input  logic pixel_clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame rotating, watchdog-bounded grant sequencer run during vertical blanking
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int N_REQ   = SCHED_N_REQ,
  parameter int TIMEOUT = SCHED_TIMEOUT,
  parameter int FCNT_W  = 16
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              video_on,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  output logic [N_REQ-1:0]  grant,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = PW + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);
  localparam logic [SW-1:0] SRV_ALL  = SW'(N_REQ);
  localparam logic [SW-1:0] SRV_LAST = SW'(N_REQ - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PTR_LAST) ? '0 : idx + 1'b1;
  endfunction

  logic vs_rise;
  logic von_rise;

  frame_update_scheduler_edge_detect u_vsync_edge (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .sig_in    (vsync),
    .rise      (vs_rise)
  );

  frame_update_scheduler_edge_detect u_video_on_edge (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .sig_in    (video_on),
    .rise      (von_rise)
  );

  sched_state_t      state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     start_q, start_d;
  logic [SW-1:0]     served_q, served_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_q, overrun_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    start_d       = start_q;
    served_d      = served_q;
    timer_d       = timer_q;
    grant_d       = grant_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = (state_q != IDLE) && vs_rise;

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d  = SCAN;
          ptr_d    = start_q;
          served_d = '0;
        end
      end
      SCAN: begin
        if (von_rise) begin
          grant_d   = '0;
          overrun_d = 1'b1;
          state_d   = IDLE;
        end else if (served_q == SRV_ALL) begin
          state_d = FINISH;
        end else if (req[ptr_q]) begin
          grant_d        = '0;
          grant_d[ptr_q] = 1'b1;
          timer_d        = '0;
          state_d        = GRANT;
        end else begin
          served_d = served_q + 1'b1;
          ptr_d    = next_idx(ptr_q);
          if (served_q == SRV_LAST) begin
            state_d = FINISH;
          end
        end
      end
      GRANT: begin
        if (von_rise) begin
          grant_d   = '0;
          overrun_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
          // done outranks the watchdog when both land on the same cycle
          if (done[ptr_q] || (timer_q == TMR_LAST)) begin
            grant_d       = '0;
            timeout_err_d = ~done[ptr_q];
            served_d      = served_q + 1'b1;
            ptr_d         = next_idx(ptr_q);
            state_d       = SCAN;
          end
        end
      end
      FINISH: begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 1'b1;
        start_d      = next_idx(start_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      start_q       <= '0;
      served_q      <= '0;
      timer_q       <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      start_q       <= start_d;
      served_q      <= served_d;
      timer_q       <= timer_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - scoreboard bench for frame_update_scheduler
module tb_frame_update_scheduler;

  localparam int K_GRANT = 0;
  localparam int K_FDONE = 1;
  localparam int K_TERR  = 2;
  localparam int K_OVR   = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic        pixel_clk;
  logic        reset;
  logic        vsync;
  logic        video_on;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  grant;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic        overrun;
  logic [15:0] frame_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic [3:0] prev_grant = 4'b0;

  frame_update_scheduler dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .vsync       (vsync),
    .video_on    (video_on),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_GRANT: return "grant";
      K_FDONE: return "frame_done";
      K_TERR:  return "timeout_err";
      default: return "overrun";
    endcase
  endfunction

  task automatic push(int k, int v, int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(int k, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=%s:%0d@%0d expected=none", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        failures++;
        $display("FAIL event actual=%s:%0d@%0d expected=%s:%0d@%0d",
                 kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (grant != prev_grant) observe(K_GRANT, int'(grant));
    prev_grant = grant;
    if (frame_done)  observe(K_FDONE, int'(frame_cnt));
    if (timeout_err) observe(K_TERR, 0);
    if (overrun)     observe(K_OVR, 0);
  end

  task automatic at_cyc(int c);
    while (cyc < c) @(negedge pixel_clk);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    @(negedge pixel_clk);
    vsync = 1'b0;
  endtask

  task automatic pulse_done(logic [3:0] v, int c);
    at_cyc(c);
    done = v;
    @(negedge pixel_clk);
    done = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=cycle_%0d expected=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    reset = 1'b1;
    vsync = 1'b0;
    video_on = 1'b0;
    req = 4'b0;
    done = 4'b0;
    repeat (3) @(negedge pixel_clk);
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    reset = 1'b0;
    repeat (3) @(negedge pixel_clk);

    // all requesting, start=0
    req = 4'b1111;
    c = cyc;
    push(K_GRANT, 1, c + 2);  push(K_GRANT, 0, c + 6);
    push(K_GRANT, 2, c + 7);  push(K_GRANT, 0, c + 11);
    push(K_GRANT, 4, c + 12); push(K_GRANT, 0, c + 16);
    push(K_GRANT, 8, c + 17); push(K_GRANT, 0, c + 21);
    push(K_FDONE, 1, c + 23);
    vs_pulse();
    at_cyc(c + 3);
    chk("busy_in_grant", int'(busy), 1);
    pulse_done(4'b0001, c + 5);
    pulse_done(4'b0010, c + 10);
    pulse_done(4'b0100, c + 15);
    pulse_done(4'b1000, c + 20);
    at_cyc(c + 24);
    chk("busy_after_frame", int'(busy), 0);
    at_cyc(c + 27);

    // rotated start=1
    c = cyc;
    push(K_GRANT, 2, c + 2);  push(K_GRANT, 0, c + 6);
    push(K_GRANT, 4, c + 7);  push(K_GRANT, 0, c + 11);
    push(K_GRANT, 8, c + 12); push(K_GRANT, 0, c + 16);
    push(K_GRANT, 1, c + 17); push(K_GRANT, 0, c + 21);
    push(K_FDONE, 2, c + 23);
    vs_pulse();
    pulse_done(4'b0010, c + 5);
    pulse_done(4'b0100, c + 10);
    pulse_done(4'b1000, c + 15);
    pulse_done(4'b0001, c + 20);
    at_cyc(c + 27);

    // empty frame: frame_done 6 cycles after vs_rise
    req = 4'b0000;
    c = cyc;
    push(K_FDONE, 3, c + 6);
    vs_pulse();
    at_cyc(c + 10);

    // watchdog on grant[2], start=3
    req = 4'b0100;
    c = cyc;
    push(K_GRANT, 4, c + 5);
    push(K_GRANT, 0, c + 1029);
    push(K_TERR, 0, c + 1029);
    push(K_FDONE, 4, c + 1031);
    vs_pulse();
    at_cyc(c + 1035);

    // done coincides with the last watchdog cycle; spurious done[3]
    req = 4'b0001;
    c = cyc;
    push(K_GRANT, 1, c + 2);
    push(K_GRANT, 0, c + 1026);
    push(K_FDONE, 5, c + 1030);
    vs_pulse();
    pulse_done(4'b1000, c + 10);
    pulse_done(4'b0001, c + 1025);
    at_cyc(c + 1034);

    // video_on rise aborts while grant[1] held, start=1
    req = 4'b0011;
    c = cyc;
    push(K_GRANT, 2, c + 2);
    push(K_GRANT, 0, c + 5);
    push(K_OVR, 0, c + 5);
    vs_pulse();
    at_cyc(c + 4);
    video_on = 1'b1;
    at_cyc(c + 8);
    video_on = 1'b0;
    at_cyc(c + 12);
    chk("busy_after_abort", int'(busy), 0);

    // start unchanged after abort
    c = cyc;
    push(K_GRANT, 2, c + 2); push(K_GRANT, 0, c + 4);
    push(K_GRANT, 1, c + 7); push(K_GRANT, 0, c + 9);
    push(K_FDONE, 6, c + 11);
    vs_pulse();
    pulse_done(4'b0010, c + 3);
    pulse_done(4'b0001, c + 8);
    at_cyc(c + 14);

    // vs_rise while busy, start=2
    req = 4'b0100;
    c = cyc;
    push(K_GRANT, 4, c + 2);
    push(K_OVR, 0, c + 5);
    push(K_GRANT, 0, c + 7);
    push(K_FDONE, 7, c + 11);
    vs_pulse();
    at_cyc(c + 4);
    vsync = 1'b1;
    at_cyc(c + 5);
    vsync = 1'b0;
    pulse_done(4'b0100, c + 6);
    at_cyc(c + 14);

    // asynchronous reset mid-grant, start=3
    req = 4'b1000;
    c = cyc;
    push(K_GRANT, 8, c + 2);
    vs_pulse();
    at_cyc(c + 4);
    push(K_GRANT, 0, c + 5);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_grant", int'(grant), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_frame_cnt", int'(frame_cnt), 0);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b0;
    repeat (2) @(negedge pixel_clk);

    // after reset, scheduling restarts at index 0
    req = 4'b1001;
    c = cyc;
    push(K_GRANT, 1, c + 2); push(K_GRANT, 0, c + 4);
    push(K_GRANT, 8, c + 7); push(K_GRANT, 0, c + 9);
    push(K_FDONE, 1, c + 11);
    vs_pulse();
    pulse_done(4'b0001, c + 3);
    pulse_done(4'b1000, c + 8);
    at_cyc(c + 16);

    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
